mipi_rx_depacker_ctrl: RTL and testbench
========================================

# mipi_rx_depacker_ctrl

Packet-level sequencer between the CSI-2 packet decoder and the RAW depacker. Accepts decoded packet headers and the 4-lane payload stream. Forwards supported RAW10/12/14 long-packet payloads to the depacker for exactly the word-count duration, then forces the inter-packet valid gap the depacker needs to reload its per-type configuration. Drops unsupported data types and decodes short packets into frame/line sync pulses.

## Interface
Parameters:
- MIN_GAP, 2: cycles `dp_data_valid_o` is held low after every forwarded packet (minimum 1).
- WC_WIDTH, 16: word-count width in bytes.

Ports:
- clk_i  in  1  byte clock. One clock domain; reset is synchronous and active-high.
- reset_i  in  1  synchronous active-high reset.
- hdr_valid_i  in  1  one-cycle strobe: header fields valid.
- hdr_data_type_i  in  6  CSI-2 data type.
- hdr_word_count_i  in  WC_WIDTH  payload byte count (long) or data field (short).
- data_valid_i  in  1  payload beat valid.
- data_i  in  32  payload beat, 4 lanes.
- dp_data_valid_o  out  1  to depacker data_valid.
- dp_data_o  out  32  to depacker data.
- dp_packet_type_o  out  3  to depacker packet_type: data type [2:0].
- frame_start_o, frame_end_o, line_start_o, line_end_o  out  1 each  one-cycle sync pulses.
- busy_o  out  1  high in any state except IDLE.
- err_unsupported_o, err_truncated_o, err_overrun_o  out  1 each  one-cycle error pulses.
- frame_count_o, line_count_o  out  16 each  statistics (see Configuration).

## Operation
- States: IDLE, PAYLOAD, DROP, GAP.
- IDLE, `hdr_valid_i`:
  - Type 0x00/0x01/0x02/0x03: pulse frame_start/frame_end/line_start/line_end; stay in IDLE.
  - Type 0x2B/0x2C/0x2D with WC>0: latch type[2:0] into `dp_packet_type_o`; load beat counter = ceil(WC/4) = (WC+3)>>2, computed at WC_WIDTH+1 bits, no overflow; go to PAYLOAD.
  - Type 0x2B/0x2C/0x2D with WC=0: go directly to GAP.
  - Other type with WC>0: pulse `err_unsupported_o`; load counter; go to DROP.
  - Other type with WC=0 (long-packet range 0x10–0x3F): pulse `err_unsupported_o`; stay in IDLE.
- PAYLOAD: each `data_valid_i` beat is registered to `dp_data_o` with `dp_data_valid_o`=1 and decrements the counter. After the last beat, go to GAP. A partial last beat is forwarded whole.
- `data_valid_i` low in PAYLOAD or DROP while counter>0: pulse `err_truncated_o`; go to GAP. The missing beats are not padded.
- DROP: consume beats without forwarding; go to GAP when the counter reaches 0.
- GAP: `dp_data_valid_o`=0 for MIN_GAP cycles, then go to IDLE. `dp_packet_type_o` holds its value until the next accepted long header.
- `hdr_valid_i` in any state other than IDLE: the header is discarded and `err_overrun_o` pulses.
- `data_valid_i` in IDLE: ignored.
- Reset: state IDLE. All outputs 0, including `dp_packet_type_o`, counters and `busy_o`. Reset mid-packet aborts immediately without an error pulse.

## Timing
- Header strobe at cycle T in IDLE: state change at T+1. The first payload beat may arrive at T+1.
- Data latency is 1 cycle: `data_i` at cycle N appears on `dp_data_o`/`dp_data_valid_o` at N+1.
- `dp_packet_type_o` is stable from T+1, before the first `dp_data_valid_o`, until the next accepted long header.
- Last beat accepted at cycle L: GAP occupies L+1..L+MIN_GAP, IDLE at L+MIN_GAP+1. The earliest next accepted header is at L+MIN_GAP+1.
- Sync and error pulses are registered: they assert the cycle after the causing input and last exactly 1 cycle.
- Truncation detected at cycle N: `err_truncated_o` at N+1; GAP starts at N+1.

## Configuration
- MIPI_RX_CTRL_STATS_EN defined:
  - `frame_count_o` increments (wrapping) on each frame_start.
  - `line_count_o` increments on each forwarded long packet and clears on frame_start. If both occur in the same cycle, clear wins.
- Not defined: both outputs are tied to 0 and no counter logic is present.

## Structure
- Shared package `mipi_csi_pkg`:
  - data-type constants (FS/FE/LS/LE, RAW10/12/14);
  - the state enum;
  - BYTES_PER_BEAT=4.
- One sub-module, `mipi_rx_beat_counter`: loads ceil(WC/4), decrements on enable, flags zero and last.

## Test plan
- RAW10 header, WC=20, 5 contiguous beats -> 5 forwarded beats at +1 latency; type=3'h3; `dp_data_valid_o` low 2 cycles; `busy_o` clears at L+3.
- RAW12 WC=6 -> 2 beats forwarded, last beat partial; type=3'h4.
- Header type 0x12, WC=8 -> `err_unsupported_o` pulse; 2 beats swallowed; `dp_data_valid_o` never asserts.
- RAW14 WC=40, `data_valid_i` drops after 3 beats -> 3 forwarded; `err_truncated_o` 1 cycle later; GAP then IDLE.
- Header during PAYLOAD -> `err_overrun_o`; current packet completes unaffected.
- FS, LS, RAW10 packet, LE, FE with MIPI_RX_CTRL_STATS_EN -> four sync pulses in order; `frame_count_o`=1, `line_count_o`=1. `reset_i` mid-payload -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mipi_csi_pkg.sv
// Shared CSI-2 definitions for the RX packet path: data types, sequencer states, beat geometry.
package mipi_csi_pkg;

    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LS       = 6'h02;
    localparam logic [5:0] DT_LE       = 6'h03;
    localparam logic [5:0] DT_RAW10    = 6'h2B;
    localparam logic [5:0] DT_RAW12    = 6'h2C;
    localparam logic [5:0] DT_RAW14    = 6'h2D;
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    localparam int BYTES_PER_BEAT = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2,
        ST_GAP     = 2'd3
    } rx_state_e;

    function automatic logic is_raw_type(input logic [5:0] dt);
        return (dt == DT_RAW10) || (dt == DT_RAW12) || (dt == DT_RAW14);
    endfunction

endpackage

// File: rtl/mipi_rx_beat_counter.sv
// Payload beat down-counter: loads ceil(word_count / BYTES_PER_BEAT), decrements per accepted beat.
module mipi_rx_beat_counter
    import mipi_csi_pkg::*;
#(
    parameter int WC_WIDTH = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                load_i,
    input  logic [WC_WIDTH-1:0] wc_i,
    input  logic                dec_i,
    output logic                zero_o,
    output logic                last_o
);

    localparam int SHIFT = $clog2(BYTES_PER_BEAT);
    localparam int RW    = WC_WIDTH + 1;
    localparam int CNT_W = RW - SHIFT;

    // One extra bit so the round-up add cannot overflow for the largest word count.
    logic [RW-1:0]    wc_round;
    logic [CNT_W-1:0] cnt_q;

    assign wc_round = {1'b0, wc_i} + RW'(BYTES_PER_BEAT - 1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= CNT_W'(wc_round >> SHIFT);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);
    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mipi_rx_depacker_ctrl.sv
// Packet sequencer between the CSI-2 decoder and the RAW depacker.
// Statistics counters are built only when MIPI_RX_CTRL_STATS_EN is defined.
module mipi_rx_depacker_ctrl
    import mipi_csi_pkg::*;
#(
    parameter int MIN_GAP  = 2,
    parameter int WC_WIDTH = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                hdr_valid_i,
    input  logic [5:0]          hdr_data_type_i,
    input  logic [WC_WIDTH-1:0] hdr_word_count_i,
    input  logic                data_valid_i,
    input  logic [31:0]         data_i,
    output logic                dp_data_valid_o,
    output logic [31:0]         dp_data_o,
    output logic [2:0]          dp_packet_type_o,
    output logic                frame_start_o,
    output logic                frame_end_o,
    output logic                line_start_o,
    output logic                line_end_o,
    output logic                busy_o,
    output logic                err_unsupported_o,
    output logic                err_truncated_o,
    output logic                err_overrun_o,
    output logic [15:0]         frame_count_o,
    output logic [15:0]         line_count_o
);

    // state   | meaning
    // IDLE    | waiting for a header; short sync packets decoded here
    // PAYLOAD | forwarding beats of a supported RAW packet
    // DROP    | swallowing beats of an unsupported long packet
    // GAP     | depacker valid held low so it can reload its type config
    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_PAYLOAD = ST_PAYLOAD;
    localparam logic [1:0] S_DROP    = ST_DROP;
    localparam logic [1:0] S_GAP     = ST_GAP;

    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [GAP_W-1:0] gap_q;

    logic hdr_take;
    logic hdr_is_raw;
    logic hdr_is_long;
    logic hdr_wc_zero;
    logic accept_long;
    logic drop_long;
    logic unsup_hdr;
    logic in_beats;
    logic beat_take;
    logic fwd_beat;
    logic truncated;
    logic enter_gap;
    logic fs_hit;
    logic cnt_zero;
    logic cnt_last;

    assign hdr_take    = hdr_valid_i && (state_q == S_IDLE);
    assign hdr_is_raw  = is_raw_type(hdr_data_type_i);
    assign hdr_is_long = (hdr_data_type_i >= DT_LONG_MIN);
    assign hdr_wc_zero = (hdr_word_count_i == '0);

    assign accept_long = hdr_take && hdr_is_raw && !hdr_wc_zero;
    assign unsup_hdr   = hdr_take && hdr_is_long && !hdr_is_raw;
    assign drop_long   = unsup_hdr && !hdr_wc_zero;
    assign fs_hit      = hdr_take && (hdr_data_type_i == DT_FS);

    assign in_beats  = (state_q == S_PAYLOAD) || (state_q == S_DROP);
    assign beat_take = in_beats && data_valid_i;
    assign fwd_beat  = (state_q == S_PAYLOAD) && data_valid_i;
    // Missing beats are not padded; the packet is simply cut short.
    assign truncated = in_beats && !data_valid_i && !cnt_zero;

    mipi_rx_beat_counter #(
        .WC_WIDTH (WC_WIDTH)
    ) u_beat_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (accept_long || drop_long),
        .wc_i    (hdr_word_count_i),
        .dec_i   (beat_take),
        .zero_o  (cnt_zero),
        .last_o  (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_long) begin
                    state_d = S_PAYLOAD;
                end else if (drop_long) begin
                    state_d = S_DROP;
                end else if (hdr_take && hdr_is_raw) begin
                    state_d = S_GAP;
                end
            end
            S_PAYLOAD, S_DROP: begin
                if (!data_valid_i || cnt_last) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_gap = (state_q != S_GAP) && (state_d == S_GAP);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            if (enter_gap) begin
                gap_q <= GAP_W'(MIN_GAP - 1);
            end else if ((state_q == S_GAP) && (gap_q != '0)) begin
                gap_q <= gap_q - GAP_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dp_data_valid_o   <= 1'b0;
            dp_data_o         <= '0;
            dp_packet_type_o  <= '0;
            frame_start_o     <= 1'b0;
            frame_end_o       <= 1'b0;
            line_start_o      <= 1'b0;
            line_end_o        <= 1'b0;
            err_unsupported_o <= 1'b0;
            err_truncated_o   <= 1'b0;
            err_overrun_o     <= 1'b0;
        end else begin
            dp_data_valid_o <= fwd_beat;
            if (fwd_beat) begin
                dp_data_o <= data_i;
            end
            if (accept_long) begin
                dp_packet_type_o <= hdr_data_type_i[2:0];
            end
            frame_start_o     <= fs_hit;
            frame_end_o       <= hdr_take && (hdr_data_type_i == DT_FE);
            line_start_o      <= hdr_take && (hdr_data_type_i == DT_LS);
            line_end_o        <= hdr_take && (hdr_data_type_i == DT_LE);
            err_unsupported_o <= unsup_hdr;
            err_truncated_o   <= truncated;
            err_overrun_o     <= hdr_valid_i && (state_q != S_IDLE);
        end
    end

    assign busy_o = (state_q != S_IDLE);

`ifdef MIPI_RX_CTRL_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] line_cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            frame_cnt_q <= '0;
            line_cnt_q  <= '0;
        end else begin
            if (fs_hit) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            // A new frame restarts the line count even if a line was accepted alongside it.
            if (fs_hit) begin
                line_cnt_q <= '0;
            end else if (accept_long) begin
                line_cnt_q <= line_cnt_q + 16'd1;
            end
        end
    end

    assign frame_count_o = frame_cnt_q;
    assign line_count_o  = line_cnt_q;
`else
    assign frame_count_o = '0;
    assign line_count_o  = '0;
`endif

endmodule

// File: tb/tb_mipi_rx_depacker_ctrl.sv
// Self-checking bench for mipi_rx_depacker_ctrl: vector table, timed corner sequences, random packets vs model.
module tb_mipi_rx_depacker_ctrl;

    localparam int MIN_GAP  = 2;
    localparam int WC_WIDTH = 16;

    logic                clk_i = 1'b0;
    logic                reset_i;
    logic                hdr_valid_i;
    logic [5:0]          hdr_data_type_i;
    logic [WC_WIDTH-1:0] hdr_word_count_i;
    logic                data_valid_i;
    logic [31:0]         data_i;
    logic                dp_data_valid_o;
    logic [31:0]         dp_data_o;
    logic [2:0]          dp_packet_type_o;
    logic                frame_start_o, frame_end_o, line_start_o, line_end_o;
    logic                busy_o;
    logic                err_unsupported_o, err_truncated_o, err_overrun_o;
    logic [15:0]         frame_count_o, line_count_o;

    mipi_rx_depacker_ctrl #(
        .MIN_GAP  (MIN_GAP),
        .WC_WIDTH (WC_WIDTH)
    ) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .hdr_valid_i       (hdr_valid_i),
        .hdr_data_type_i   (hdr_data_type_i),
        .hdr_word_count_i  (hdr_word_count_i),
        .data_valid_i      (data_valid_i),
        .data_i            (data_i),
        .dp_data_valid_o   (dp_data_valid_o),
        .dp_data_o         (dp_data_o),
        .dp_packet_type_o  (dp_packet_type_o),
        .frame_start_o     (frame_start_o),
        .frame_end_o       (frame_end_o),
        .line_start_o      (line_start_o),
        .line_end_o        (line_end_o),
        .busy_o            (busy_o),
        .err_unsupported_o (err_unsupported_o),
        .err_truncated_o   (err_truncated_o),
        .err_overrun_o     (err_overrun_o),
        .frame_count_o     (frame_count_o),
        .line_count_o      (line_count_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Running totals observed mid-cycle; transactions work on differences.
    logic [31:0] got_q[$];
    int tot_fs = 0, tot_fe = 0, tot_ls = 0, tot_le = 0;
    int tot_unsup = 0, tot_trunc = 0, tot_ovr = 0;

    always @(negedge clk_i) begin
        if (dp_data_valid_o) got_q.push_back(dp_data_o);
        tot_fs    += int'(frame_start_o);
        tot_fe    += int'(frame_end_o);
        tot_ls    += int'(line_start_o);
        tot_le    += int'(line_end_o);
        tot_unsup += int'(err_unsupported_o);
        tot_trunc += int'(err_truncated_o);
        tot_ovr   += int'(err_overrun_o);
    end

    // Reference state: last accepted RAW type, frame and line statistics.
    logic [2:0] m_type;
    int         m_frames;
    int         m_lines;

    logic [31:0] sent_q[$];

    typedef struct {
        logic [5:0] dt;
        int         wc;
        int         nb;
        int         exp_fwd;
        int         exp_unsup;
        int         exp_trunc;
        logic [3:0] exp_sync;   // bit n = pulse for data type n (FS, FE, LS, LE)
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic is_raw(input logic [5:0] dt);
        return (dt == 6'h2B) || (dt == 6'h2C) || (dt == 6'h2D);
    endfunction

    function automatic void predict(input logic [5:0] dt, input int wc, input int nb,
                                    output int fwd, output int unsup, output int trunc,
                                    output logic [3:0] sync);
        int need;
        need  = (wc + 3) / 4;
        fwd   = 0;
        unsup = 0;
        trunc = 0;
        sync  = 4'b0000;
        if (dt <= 6'h03) begin
            sync[dt[1:0]] = 1'b1;
        end else if (is_raw(dt)) begin
            if (wc > 0) begin
                fwd   = (nb < need) ? nb : need;
                trunc = (nb < need) ? 1 : 0;
            end
        end else if (dt >= 6'h10) begin
            unsup = 1;
            if (wc > 0) trunc = (nb < need) ? 1 : 0;
        end
    endfunction

    task automatic model_header(input logic [5:0] dt, input int wc);
        if (dt == 6'h00) begin
            m_frames = m_frames + 1;
            m_lines  = 0;
        end else if (is_raw(dt) && wc > 0) begin
            m_type  = dt[2:0];
            m_lines = m_lines + 1;
        end
    endtask

    task automatic check_state(input string name);
        check({name, "_type"}, dp_packet_type_o, m_type);
`ifdef MIPI_RX_CTRL_STATS_EN
        check({name, "_frames"}, frame_count_o, m_frames & 16'hFFFF);
        check({name, "_lines"}, line_count_o, m_lines & 16'hFFFF);
`else
        check({name, "_frames"}, frame_count_o, 0);
        check({name, "_lines"}, line_count_o, 0);
`endif
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy_o && n < 40) begin
            @(posedge clk_i); #1;
            n++;
        end
        check({name, "_idle_timeout"}, busy_o, 1'b0);
    endtask

    task automatic run_txn(input string name, input logic [5:0] dt, input int wc, input int nb,
                           input int ovr_k, input int exp_fwd, input int exp_unsup,
                           input int exp_trunc, input logic [3:0] exp_sync);
        int base, b_fs, b_fe, b_ls, b_le, b_un, b_tr, b_ov, bad;
        sent_q.delete();
        base = got_q.size();
        b_fs = tot_fs; b_fe = tot_fe; b_ls = tot_ls; b_le = tot_le;
        b_un = tot_unsup; b_tr = tot_trunc; b_ov = tot_ovr;
        @(posedge clk_i); #1;
        hdr_valid_i      = 1'b1;
        hdr_data_type_i  = dt;
        hdr_word_count_i = 16'(wc);
        data_valid_i     = 1'b0;
        for (int k = 0; k < nb; k++) begin
            @(posedge clk_i); #1;
            hdr_valid_i      = (k == ovr_k);
            hdr_data_type_i  = 6'h2C;
            hdr_word_count_i = 16'd4;
            data_valid_i     = 1'b1;
            data_i           = $urandom;
            sent_q.push_back(data_i);
        end
        @(posedge clk_i); #1;
        hdr_valid_i  = 1'b0;
        data_valid_i = 1'b0;
        wait_idle(name);
        repeat (2) @(posedge clk_i);
        #1;
        check({name, "_fwd_beats"}, got_q.size() - base, exp_fwd);
        bad = 0;
        for (int i = 0; i < exp_fwd && i < sent_q.size() && base + i < got_q.size(); i++)
            if (got_q[base + i] !== sent_q[i]) bad++;
        check({name, "_data"}, bad, 0);
        check({name, "_unsup"}, tot_unsup - b_un, exp_unsup);
        check({name, "_trunc"}, tot_trunc - b_tr, exp_trunc);
        check({name, "_overrun"}, tot_ovr - b_ov, (ovr_k >= 0) ? 1 : 0);
        check({name, "_sync"}, {8'(tot_le - b_le), 8'(tot_ls - b_ls), 8'(tot_fe - b_fe), 8'(tot_fs - b_fs)},
              {8'(exp_sync[3]), 8'(exp_sync[2]), 8'(exp_sync[1]), 8'(exp_sync[0])});
        model_header(dt, wc);
        check_state(name);
    endtask

    // Cycle-exact sequence. Cycle 0 carries the main header; later headers are RAW12 WC=4.
    task automatic timed_seq(input string name, input logic [5:0] dt, input int wc,
                             input logic [15:0] hdr_m, input logic [15:0] dv_m,
                             input logic [15:0] e_valid, input logic [15:0] e_busy,
                             input logic [15:0] e_trunc, input logic [15:0] e_ovr);
        logic [31:0] beats[$];
        int bi;
        bi = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk_i); #1;
            hdr_valid_i      = hdr_m[i];
            hdr_data_type_i  = (i == 0) ? dt : 6'h2C;
            hdr_word_count_i = (i == 0) ? 16'(wc) : 16'd4;
            data_valid_i     = dv_m[i];
            if (dv_m[i]) begin
                data_i = $urandom;
                beats.push_back(data_i);
            end
            @(negedge clk_i);
            check($sformatf("%s_c%0d", name, i), {dp_data_valid_o, busy_o, err_truncated_o, err_overrun_o},
                  {e_valid[i], e_busy[i], e_trunc[i], e_ovr[i]});
            if (dp_data_valid_o && bi < beats.size()) begin
                check($sformatf("%s_data%0d", name, bi), dp_data_o, beats[bi]);
                bi++;
            end
        end
        hdr_valid_i  = 1'b0;
        data_valid_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fwd, unsup, trunc, need, r, wc, nb, ovr_k, lim;
        logic [5:0] dt;
        logic [3:0] sync;

        tbl[0]  = '{6'h00, 0,  0, 0, 0, 0, 4'b0001};
        tbl[1]  = '{6'h02, 0,  0, 0, 0, 0, 4'b0100};
        tbl[2]  = '{6'h2B, 20, 5, 5, 0, 0, 4'b0000};
        tbl[3]  = '{6'h03, 0,  0, 0, 0, 0, 4'b1000};
        tbl[4]  = '{6'h01, 0,  0, 0, 0, 0, 4'b0010};
        tbl[5]  = '{6'h2C, 6,  2, 2, 0, 0, 4'b0000};
        tbl[6]  = '{6'h12, 8,  2, 0, 1, 0, 4'b0000};
        tbl[7]  = '{6'h2D, 40, 3, 3, 0, 1, 4'b0000};
        tbl[8]  = '{6'h12, 0,  0, 0, 1, 0, 4'b0000};
        tbl[9]  = '{6'h2B, 0,  0, 0, 0, 0, 4'b0000};
        tbl[10] = '{6'h2B, 1,  1, 1, 0, 0, 4'b0000};
        tbl[11] = '{6'h3F, 4,  0, 0, 1, 1, 4'b0000};
        tbl[12] = '{6'h2C, 13, 6, 4, 0, 0, 4'b0000};
        tbl[13] = '{6'h2D, 3,  1, 1, 0, 0, 4'b0000};

        reset_i          = 1'b1;
        hdr_valid_i      = 1'b0;
        hdr_data_type_i  = '0;
        hdr_word_count_i = '0;
        data_valid_i     = 1'b0;
        data_i           = '0;
        m_type   = 3'd0;
        m_frames = 0;
        m_lines  = 0;
        repeat (3) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        @(negedge clk_i);
        check("reset_state", {dp_data_valid_o, dp_data_o, dp_packet_type_o, busy_o, frame_start_o,
              frame_end_o, line_start_o, line_end_o, err_unsupported_o, err_truncated_o,
              err_overrun_o, frame_count_o, line_count_o}, '0);

        for (int i = 0; i < 14; i++)
            run_txn($sformatf("tbl%0d", i), tbl[i].dt, tbl[i].wc, tbl[i].nb, -1,
                    tbl[i].exp_fwd, tbl[i].exp_unsup, tbl[i].exp_trunc, tbl[i].exp_sync);

        // RAW10 WC=20: beats 1..5, output 2..6, GAP, idle from cycle 8.
        timed_seq("raw10_timing", 6'h2B, 20, 16'h0001, 16'h003E, 16'h007C, 16'h00FE, 16'h0000, 16'h0000);
        model_header(6'h2B, 20);
        // RAW14 WC=40 cut after 3 beats: truncation seen at cycle 4, pulse at 5.
        timed_seq("raw14_trunc", 6'h2D, 40, 16'h0001, 16'h000E, 16'h001C, 16'h007E, 16'h0020, 16'h0000);
        model_header(6'h2D, 40);
        // RAW12 WC=8 with an extra header on the first beat: discarded, packet intact.
        timed_seq("overrun", 6'h2C, 8, 16'h0003, 16'h0006, 16'h000C, 16'h001E, 16'h0000, 16'h0004);
        model_header(6'h2C, 8);
        // Back-to-back: header in last GAP cycle rejected, header at L+MIN_GAP+1 accepted.
        timed_seq("back2back", 6'h2B, 4, 16'h0019, 16'h0022, 16'h0044, 16'h00EE, 16'h0000, 16'h0010);
        model_header(6'h2B, 4);
        model_header(6'h2C, 4);
        check_state("after_timed");

        // Reset in the middle of a payload.
        @(posedge clk_i); #1;
        hdr_valid_i = 1'b1; hdr_data_type_i = 6'h2B; hdr_word_count_i = 16'd40;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
            hdr_valid_i = 1'b0; data_valid_i = 1'b1; data_i = $urandom;
        end
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        @(negedge clk_i);
        check("reset_mid_pre", {dp_data_valid_o, busy_o}, 2'b11);
        @(negedge clk_i);
        check("reset_mid", {dp_data_valid_o, dp_data_o, dp_packet_type_o, busy_o, frame_start_o,
              frame_end_o, line_start_o, line_end_o, err_unsupported_o, err_truncated_o,
              err_overrun_o, frame_count_o, line_count_o}, '0);
        #1;
        reset_i = 1'b0; data_valid_i = 1'b0;
        m_type = 3'd0; m_frames = 0; m_lines = 0;
        @(posedge clk_i); #1;
        check("post_reset_idle", {busy_o, err_truncated_o}, 2'b00);

        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                dt = 6'($urandom_range(0, 3));
            end else if (r < 7) begin
                dt = 6'(32'h2B + $urandom_range(0, 2));
            end else begin
                dt = 6'($urandom_range(16, 63));
                if (is_raw(dt)) dt = 6'h1E;
            end
            if (dt <= 6'h03) begin
                wc = 0;
                nb = 0;
            end else begin
                wc = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 48);
                need = (wc + 3) / 4;
                nb = ($urandom_range(0, 9) < 7) ? need : $urandom_range(0, need + 2);
            end
            ovr_k = -1;
            need = (wc + 3) / 4;
            lim = (nb < need) ? nb : need;
            if (dt >= 6'h10 && wc > 0 && lim > 0 && $urandom_range(0, 3) == 0)
                ovr_k = $urandom_range(0, lim - 1);
            predict(dt, wc, nb, fwd, unsup, trunc, sync);
            run_txn($sformatf("rnd%0d_dt%0h_wc%0d_nb%0d", t, dt, wc, nb), dt, wc, nb, ovr_k,
                    fwd, unsup, trunc, sync);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
